pipe_slice_chain: RTL
=====================

Name: pipe_slice_chain

Overview:
- Parametrised chain of STAGES full-throughput valid/ready register slices, each with a one-entry skid buffer, so backpressure never drops or duplicates data.
- Adds a synchronous flush, an occupancy counter and a STAGES=0 pass-through mode.
- Inserted on long datapaths between producer/consumer blocks to break timing paths on data, valid and ready.

Parameters:
- bus_width, 8, data width in bits (>=1).
- STAGES, 2, number of slices in series (0..16); 0 = combinational wire-through.
- CNT_W, $clog2(2*STAGES+1) (minimum 1), width of occupancy output.

Ports:
- clk  input  1  clock, all state on posedge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous clear of all held entries.
- valide_in  input  1  upstream data valid.
- Datain  input  bus_width  upstream data.
- ready_out  output  1  block can accept; a transfer occurs when valide_in & ready_out.
- valide_out  output  1  downstream data valid.
- Dataout  output  bus_width  downstream data.
- ready_in  input  1  downstream can accept; a transfer occurs when valide_out & ready_in.
- occupancy  output  CNT_W  number of entries currently held (0..2*STAGES).

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Slice k (k=0 at input) has main reg (m_v, m_d) and skid reg (s_v, s_d); slice input = previous slice output; last slice main drives valide_out/Dataout.
- Slice in_ready = !s_v (registered, no combinational ready path between slices).
- Slice update, when out_ready | !m_v:
  - m_d <= s_v ? s_d : in_data.
  - m_v <= s_v | (in_valid & in_ready).
  - s_v <= 0.
- Slice update otherwise (stalled): if in_valid & in_ready then s_v <= 1, s_d <= in_data; m unchanged.
- ready_out = !s_v of slice 0 & !flush & !rst. This is the only combinational input-to-output path.
- Latency: STAGES cycles from input fire to valide_out with ready_in held 1. Throughput: 1 beat/cycle sustained.
- Ordering: strict FIFO; no beat lost or duplicated under any ready_in pattern.
- Capacity: 2*STAGES beats. With ready_in=0 permanently, ready_out drops after exactly 2*STAGES accepted beats, once the chain has filled.
- occupancy:
  - Register updated +1 on input fire, -1 on output fire, unchanged when both fire.
  - Equals the count of set m_v/s_v bits.
  - Never exceeds 2*STAGES or underflows.
- flush:
  - All m_v, s_v, occupancy <= 0 next cycle; data regs <= 0.
  - ready_out is 0 during the flush cycle, so no input is accepted.
  - A valide_out & ready_in transfer in the flush cycle still counts as delivered.
  - flush wins over any simultaneous load.
- Reset (rst=1): all valid bits, data regs and occupancy <= 0; ready_out=0 while rst=1.
- Reset values seen in the first cycle after rst deasserts: valide_out=0, Dataout=0, occupancy=0, ready_out=1.
- rst mid-operation: held beats are discarded exactly as for flush. rst takes priority over flush.
- STAGES=0 mode:
  - Dataout=Datain, valide_out=valide_in, ready_out=ready_in, occupancy=0.
  - flush ignored. No registers.
- Data regs load only on the conditions above; they hold their value while stalled, and Dataout stays stable while valide_out=1 and ready_in=0.

Test Plan:
- Streaming, STAGES=2, bus_width=8, ready_in=1, inputs 0x01..0x10 back-to-back:
  - 0x01 appears on Dataout exactly 2 cycles after its input fire.
  - 16 outputs in order, no bubbles.
  - occupancy stays at 2 in steady state.
- Full stall, STAGES=3: ready_in=0, valide_in=1 with 0xA0..0xAF:
  - ready_out falls after the 6th accepted beat; occupancy=6.
  - Release ready_in=1: 0xA0..0xA5 emerge in order, then streaming resumes with no loss.
- Random backpressure, STAGES=4, 1000 beats, ready_in and valide_in random at 50%:
  - Scoreboard shows exact in-order delivery.
  - occupancy always matches the reference count.
  - Dataout stable whenever stalled.
- Flush with occupancy=5 and simultaneous valide_in=1, ready_in=1:
  - Beat on Dataout is delivered that cycle; input beat is not accepted (ready_out=0).
  - Next cycle: valide_out=0, occupancy=0, ready_out=1.
- Reset mid-stream (rst pulsed 1 cycle with 4 beats held, STAGES=2):
  - Next cycle: valide_out=0, Dataout=0x00, occupancy=0, ready_out=1.
  - No stale beats emerge afterwards.
- STAGES=0, toggling ready_in/valide_in with Datain=0x5A:
  - Outputs follow inputs combinationally in the same cycle.
  - occupancy=0 throughout; flush has no effect.

Source files
------------

// File: rtl/pipe_slice_chain.sv
// Chain of STAGES valid/ready register slices, each with a one-entry skid buffer,
// plus synchronous flush, an occupancy counter and a STAGES=0 wire-through mode.
module pipe_slice_chain #(
  parameter int unsigned bus_width = 8,
  parameter int unsigned STAGES    = 2,
  parameter int unsigned CNT_W     = (STAGES == 0) ? 1 : $clog2(2 * STAGES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 valide_in,
  input  logic [bus_width-1:0] Datain,
  output logic                 ready_out,
  output logic                 valide_out,
  output logic [bus_width-1:0] Dataout,
  input  logic                 ready_in,
  output logic [CNT_W-1:0]     occupancy
);

  generate
    if (STAGES == 0) begin : g_wire
      logic unused_c;
      assign unused_c   = ^{clk, rst, flush};
      assign Dataout    = Datain;
      assign valide_out = valide_in;
      assign ready_out  = ready_in;
      assign occupancy  = '0;
    end else begin : g_chain
      localparam int unsigned N = STAGES;

      logic [N-1:0]                m_v_q, m_v_d, s_v_q, s_v_d;
      logic [N-1:0][bus_width-1:0] m_d_q, m_d_d, s_d_q, s_d_d;
      logic [N-1:0]                in_v_c, in_rdy_c, out_rdy_c;
      logic [N-1:0][bus_width-1:0] in_d_c;
      logic [CNT_W-1:0]            cnt_q, cnt_d;
      logic                        in_fire_c, out_fire_c;

      // Slice k consumes slice k-1's main register; ready between slices is !s_v (registered).
      always_comb begin
        in_v_c      = '0;
        in_d_c      = '0;
        in_rdy_c    = '0;
        out_rdy_c   = '0;
        in_v_c[0]   = valide_in;
        in_d_c[0]   = Datain;
        in_rdy_c[0] = ready_out;
        for (int k = 1; k < int'(N); k++) begin
          in_v_c[k]   = m_v_q[k-1];
          in_d_c[k]   = m_d_q[k-1];
          in_rdy_c[k] = !s_v_q[k];
        end
        for (int k = 0; k < int'(N) - 1; k++) begin
          out_rdy_c[k] = !s_v_q[k+1];
        end
        out_rdy_c[N-1] = ready_in;
      end

      assign ready_out  = !s_v_q[0] && !flush && !rst;
      assign in_fire_c  = valide_in && ready_out;
      assign out_fire_c = m_v_q[N-1] && ready_in;

      always_comb begin
        m_v_d = m_v_q;
        s_v_d = s_v_q;
        m_d_d = m_d_q;
        s_d_d = s_d_q;
        cnt_d = cnt_q;
        if (flush) begin
          m_v_d = '0;
          s_v_d = '0;
          m_d_d = '0;
          s_d_d = '0;
          cnt_d = '0;
        end else begin
          for (int k = 0; k < int'(N); k++) begin
            if (out_rdy_c[k] || !m_v_q[k]) begin
              m_d_d[k] = s_v_q[k] ? s_d_q[k] : in_d_c[k];
              m_v_d[k] = s_v_q[k] || (in_v_c[k] && in_rdy_c[k]);
              s_v_d[k] = 1'b0;
            end else if (in_v_c[k] && in_rdy_c[k]) begin
              // Downstream stalled: park the incoming beat in the skid register.
              s_v_d[k] = 1'b1;
              s_d_d[k] = in_d_c[k];
            end
          end
          cnt_d = cnt_q + CNT_W'(in_fire_c) - CNT_W'(out_fire_c);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          m_v_q <= '0;
          s_v_q <= '0;
          m_d_q <= '0;
          s_d_q <= '0;
          cnt_q <= '0;
        end else begin
          m_v_q <= m_v_d;
          s_v_q <= s_v_d;
          m_d_q <= m_d_d;
          s_d_q <= s_d_d;
          cnt_q <= cnt_d;
        end
      end

      assign valide_out = m_v_q[N-1];
      assign Dataout    = m_d_q[N-1];
      assign occupancy  = cnt_q;
    end
  endgenerate

endmodule
